// File: rtl/cook_time_entry.sv
`default_nettype none
// ============================================================================
// cook_time_entry : debounced front-panel mm:ss entry, arm/alarm FSM, BCD out
// Revision 1.0 - initial release
// ============================================================================
module cook_time_entry #(
    parameter int DEBOUNCE_CYC  = 500000,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000,
    parameter int SEC_STEP      = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_min,
    input  logic        btn_sec,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic        timer_done,
    output logic [12:0] cookTime,
    output logic        timeinputdone,
    output logic        alarm,
    output logic [3:0]  min_t,
    output logic [3:0]  min_o,
    output logic [3:0]  sec_t,
    output logic [3:0]  sec_o,
    output logic [1:0]  state
);

    localparam int CNT_W   = $clog2(DEBOUNCE_CYC + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    localparam logic [CNT_W-1:0] c_deb   = CNT_W'(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);
    localparam logic [REP_W-1:0] c_rdly  = REP_W'(REPEAT_DELAY);
    localparam logic [REP_W-1:0] c_rper  = REP_W'(REPEAT_PERIOD);
    localparam logic [REP_W-1:0] c_rone  = REP_W'(1);
    localparam logic [6:0]       c_step7 = 7'(SEC_STEP);
    localparam logic [5:0]       c_step6 = 6'(SEC_STEP);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EDIT  = 2'd1,
        ST_ARMED = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // bit order: 0 min, 1 sec, 2 start, 3 clear
    logic [3:0] w_raw;
    logic [3:0] w_evt;
    logic [3:0] r_evt;

    assign w_raw = {btn_clear, btn_start, btn_sec, btn_min};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        logic             r_s1;
        logic             r_s2;
        logic             r_lvl;
        logic             r_armed;
        logic [CNT_W-1:0] r_cnt;
        logic [CNT_W-1:0] w_cnt_nxt;
        logic             w_reach;
        logic             w_accept;

        // w_reach marks the one cycle a run of equal samples hits DEBOUNCE_CYC
        always_comb begin
            w_cnt_nxt = c_one;
            if (r_s2 == r_lvl) begin
                w_cnt_nxt = (r_cnt == c_deb) ? r_cnt : r_cnt + c_one;
            end
            w_reach  = (w_cnt_nxt == c_deb) && ((r_s2 != r_lvl) || (r_cnt != c_deb));
            w_accept = w_reach && r_s2 && r_armed;
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_s1    <= 1'b0;
                r_s2    <= 1'b0;
                r_lvl   <= 1'b0;
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else begin
                r_s1  <= w_raw[i];
                r_s2  <= r_s1;
                r_lvl <= r_s2;
                r_cnt <= w_cnt_nxt;
                if (w_accept) begin
                    r_armed <= 1'b0;
                end else if (w_reach && !r_s2) begin
                    r_armed <= 1'b1;
                end
            end
        end

        if (i < 2) begin : g_rep
            logic             r_rep_on;
            logic             r_rep_first;
            logic [REP_W-1:0] r_rcnt;
            logic [REP_W-1:0] w_rcnt_inc;
            logic             w_rep_fire;

            always_comb begin
                w_rcnt_inc = r_rcnt + c_rone;
                w_rep_fire = r_rep_on && r_s2 &&
                             (w_rcnt_inc == (r_rep_first ? c_rdly : c_rper));
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_rep_on    <= 1'b0;
                    r_rep_first <= 1'b0;
                    r_rcnt      <= '0;
                end else if (w_accept) begin
                    r_rep_on    <= 1'b1;
                    r_rep_first <= 1'b1;
                    r_rcnt      <= '0;
                end else if (!r_s2) begin
                    r_rep_on <= 1'b0;
                end else if (r_rep_on) begin
                    if (w_rep_fire) begin
                        r_rcnt      <= '0;
                        r_rep_first <= 1'b0;
                    end else begin
                        r_rcnt <= w_rcnt_inc;
                    end
                end
            end

            assign w_evt[i] = w_accept || w_rep_fire;
        end else begin : g_norep
            assign w_evt[i] = w_accept;
        end
    end

    state_t      r_state;
    state_t      w_state_nxt;
    logic [5:0]  r_min;
    logic [5:0]  r_sec;
    logic [5:0]  w_min_nxt;
    logic [5:0]  w_sec_nxt;
    logic [5:0]  w_upd_min;
    logic [5:0]  w_upd_sec;
    logic [6:0]  w_sec_sum;
    logic [12:0] r_cook;
    logic        r_td_q;
    logic        w_td_edge;
    logic        w_has_time;

    assign w_td_edge  = timer_done && !r_td_q;
    assign w_has_time = (r_min != 6'd0) || (r_sec != 6'd0);

    // Seconds step first (carry into minutes, 59:59 ceiling), then minute step
    always_comb begin
        w_upd_min = r_min;
        w_upd_sec = r_sec;
        w_sec_sum = {1'b0, r_sec} + c_step7;
        if (r_evt[1]) begin
            if (w_sec_sum >= 7'd60) begin
                if (r_min == 6'd59) begin
                    w_upd_min = 6'd59;
                    w_upd_sec = 6'd59;
                end else begin
                    w_upd_min = r_min + 6'd1;
                    w_upd_sec = r_sec + c_step6 - 6'd60;
                end
            end else begin
                w_upd_sec = r_sec + c_step6;
            end
        end
        if (r_evt[0] && (w_upd_min != 6'd59)) begin
            w_upd_min = w_upd_min + 6'd1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_min_nxt   = r_min;
        w_sec_nxt   = r_sec;
        case (r_state)
            ST_IDLE: begin
                if (!r_evt[3] && !r_evt[2] && (r_evt[0] || r_evt[1])) begin
                    w_state_nxt = ST_EDIT;
                    w_min_nxt   = w_upd_min;
                    w_sec_nxt   = w_upd_sec;
                end
            end
            ST_EDIT: begin
                if (r_evt[3]) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = 6'd0;
                    w_sec_nxt   = 6'd0;
                end else if (r_evt[2]) begin
                    if (w_has_time) begin
                        w_state_nxt = ST_ARMED;
                    end
                end else if (r_evt[0] || r_evt[1]) begin
                    w_min_nxt = w_upd_min;
                    w_sec_nxt = w_upd_sec;
                end
            end
            ST_ARMED: begin
                if (r_evt[3]) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = 6'd0;
                    w_sec_nxt   = 6'd0;
                end else if (w_td_edge) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (r_evt[3]) begin
                    w_state_nxt = ST_IDLE;
                    w_min_nxt   = 6'd0;
                    w_sec_nxt   = 6'd0;
                end else if (r_evt[2]) begin
                    w_state_nxt = ST_ARMED;
                end else if (r_evt[0] || r_evt[1]) begin
                    w_state_nxt = ST_EDIT;
                    w_min_nxt   = w_upd_min;
                    w_sec_nxt   = w_upd_sec;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_min   <= 6'd0;
            r_sec   <= 6'd0;
            r_cook  <= 13'd0;
            r_td_q  <= 1'b0;
            r_evt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_min   <= w_min_nxt;
            r_sec   <= w_sec_nxt;
            r_cook  <= 13'(r_min) * 13'd60 + 13'(r_sec);
            r_td_q  <= timer_done;
            r_evt   <= w_evt;
        end
    end

    assign cookTime      = r_cook;
    assign state         = r_state;
    assign timeinputdone = (r_state == ST_ARMED);
    assign alarm         = (r_state == ST_DONE);
    assign min_t         = 4'(r_min / 6'd10);
    assign min_o         = 4'(r_min % 6'd10);
    assign sec_t         = 4'(r_sec / 6'd10);
    assign sec_o         = 4'(r_sec % 6'd10);

endmodule
`default_nettype wire

// File: tb/tb_cook_time_entry.sv
`default_nettype none
// ============================================================================
// tb_cook_time_entry : randomized bench with a behavioural cook-time model
// Revision 1.0 - initial release
// ============================================================================
module tb_cook_time_entry;
    localparam int D    = 4;
    localparam int RD   = 20;
    localparam int RP   = 8;
    localparam int STEP = 10;

    localparam int S_IDLE  = 0;
    localparam int S_EDIT  = 1;
    localparam int S_ARMED = 2;
    localparam int S_DONE  = 3;

    localparam logic [3:0] c_min   = 4'b0001;
    localparam logic [3:0] c_sec   = 4'b0010;
    localparam logic [3:0] c_start = 4'b0100;
    localparam logic [3:0] c_clear = 4'b1000;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        btn_min    = 1'b0;
    logic        btn_sec    = 1'b0;
    logic        btn_start  = 1'b0;
    logic        btn_clear  = 1'b0;
    logic        timer_done = 1'b0;
    logic [12:0] cookTime;
    logic        timeinputdone;
    logic        alarm;
    logic [3:0]  min_t;
    logic [3:0]  min_o;
    logic [3:0]  sec_t;
    logic [3:0]  sec_o;
    logic [1:0]  state;

    int n_cmp = 0;
    int n_bad = 0;

    cook_time_entry #(
        .DEBOUNCE_CYC (D),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .SEC_STEP     (STEP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .btn_min      (btn_min),
        .btn_sec      (btn_sec),
        .btn_start    (btn_start),
        .btn_clear    (btn_clear),
        .timer_done   (timer_done),
        .cookTime     (cookTime),
        .timeinputdone(timeinputdone),
        .alarm        (alarm),
        .min_t        (min_t),
        .min_o        (min_o),
        .sec_t        (sec_t),
        .sec_o        (sec_o),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Model: setpoint kept as total seconds; buttons as delayed samples plus run lengths
    int m_total = 0;
    int m_cook  = 0;
    int m_state = S_IDLE;
    int td_prev = 0;
    int p1[4];
    int p2[4];
    int prev_s[4];
    int run[4];
    int armed[4];
    int rep_on[4];
    int since[4];
    int ev_pend[4];

    function automatic int bump(input int t, input int mn, input int sc);
        int r;
        r = t;
        if (sc != 0) r = (r + STEP > 3599) ? 3599 : r + STEP;
        if (mn != 0 && r / 60 < 59) r = r + 60;
        return r;
    endfunction

    task automatic apply_events(input int tedge);
        int mn, sc, st, cl;
        mn = ev_pend[0];
        sc = ev_pend[1];
        st = ev_pend[2];
        cl = ev_pend[3];
        if (m_state == S_IDLE) begin
            if (cl == 0 && st == 0 && (mn != 0 || sc != 0)) begin
                m_total = bump(0, mn, sc);
                m_state = S_EDIT;
            end
        end else if (cl != 0) begin
            m_total = 0;
            m_state = S_IDLE;
        end else if (m_state == S_EDIT) begin
            if (st != 0) begin
                if (m_total != 0) m_state = S_ARMED;
            end else if (mn != 0 || sc != 0) begin
                m_total = bump(m_total, mn, sc);
            end
        end else if (m_state == S_ARMED) begin
            if (tedge != 0) m_state = S_DONE;
        end else begin
            if (st != 0) begin
                m_state = S_ARMED;
            end else if (mn != 0 || sc != 0) begin
                m_total = bump(m_total, mn, sc);
                m_state = S_EDIT;
            end
        end
    endtask

    task automatic model_step();
        int raw[4];
        int ev_now[4];
        int s;
        int tedge;
        raw[0] = int'(btn_min);
        raw[1] = int'(btn_sec);
        raw[2] = int'(btn_start);
        raw[3] = int'(btn_clear);
        if (!rst_n) begin
            m_total = 0;
            m_cook  = 0;
            m_state = S_IDLE;
            td_prev = 0;
            for (int b = 0; b < 4; b++) begin
                p1[b] = 0; p2[b] = 0; prev_s[b] = 0; run[b] = 0;
                armed[b] = 1; rep_on[b] = 0; since[b] = 0; ev_pend[b] = 0;
            end
        end else begin
            tedge  = (timer_done && td_prev == 0) ? 1 : 0;
            m_cook = m_total;
            apply_events(tedge);
            td_prev = int'(timer_done);
            for (int b = 0; b < 4; b++) begin
                s     = p2[b];
                p2[b] = p1[b];
                p1[b] = raw[b];
                run[b]    = (s == prev_s[b]) ? run[b] + 1 : 1;
                prev_s[b] = s;
                ev_now[b] = 0;
                if (s != 0 && run[b] == D && armed[b] != 0) begin
                    ev_now[b] = 1;
                    armed[b]  = 0;
                    rep_on[b] = (b < 2) ? 1 : 0;
                    since[b]  = 0;
                end else begin
                    if (s == 0 && run[b] == D) armed[b] = 1;
                    if (rep_on[b] != 0) begin
                        if (s == 0) begin
                            rep_on[b] = 0;
                        end else begin
                            since[b] = since[b] + 1;
                            if (since[b] == RD || (since[b] > RD && (since[b] - RD) % RP == 0))
                                ev_now[b] = 1;
                        end
                    end
                end
            end
            for (int b = 0; b < 4; b++) ev_pend[b] = ev_now[b];
        end
    endtask

    task automatic compare_step();
        int mm, ss;
        bit ok;
        mm = m_total / 60;
        ss = m_total % 60;
        ok = (int'(cookTime) == m_cook) && (int'(state) == m_state) &&
             (timeinputdone == (m_state == S_ARMED)) && (alarm == (m_state == S_DONE)) &&
             (int'(min_t) == mm / 10) && (int'(min_o) == mm % 10) &&
             (int'(sec_t) == ss / 10) && (int'(sec_o) == ss % 10);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL cycle_check t=%0t: got cook=%0d st=%0d tid=%0b alm=%0b bcd=%0d%0d:%0d%0d want cook=%0d st=%0d tid=%0b alm=%0b bcd=%0d%0d:%0d%0d",
                     $time, cookTime, state, timeinputdone, alarm, min_t, min_o, sec_t, sec_o,
                     m_cook, m_state, (m_state == S_ARMED), (m_state == S_DONE),
                     mm / 10, mm % 10, ss / 10, ss % 10);
        end
    endtask

    always @(posedge clk) model_step();
    always @(negedge clk) compare_step();

    task automatic lit(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] m, input logic v);
        if (m[0]) btn_min   = v;
        if (m[1]) btn_sec   = v;
        if (m[2]) btn_start = v;
        if (m[3]) btn_clear = v;
    endtask

    task automatic press(input logic [3:0] m, input int hold, input int low);
        drive(m, 1'b1);
        tick(hold);
        drive(m, 1'b0);
        tick(low);
    endtask

    task automatic tap(input logic [3:0] m);
        press(m, D + int'($urandom_range(0, 6)), D + 3 + int'($urandom_range(0, 4)));
    endtask

    initial begin
        int dig_lat;
        int ck_lat;
        logic [15:0] old_dig;
        logic [12:0] old_ck;
        int rate;

        rst_n = 1'b0;
        tick(3);
        lit("reset_cook", int'(cookTime), 0);
        lit("reset_state", int'(state), S_IDLE);
        lit("reset_tid", int'(timeinputdone), 0);
        rst_n = 1'b1;
        tick(2);

        repeat (3) tap(c_sec);
        lit("three_sec_cook", int'(cookTime), 30);
        lit("three_sec_model", m_total, 30);
        repeat (2) tap(c_min);
        lit("two_min_cook", int'(cookTime), 150);
        lit("two_min_model", m_total, 150);
        lit("two_min_state", int'(state), S_EDIT);
        lit("two_min_min_o", int'(min_o), 2);
        lit("two_min_sec_t", int'(sec_t), 3);

        tap(c_clear);
        lit("clear_state", int'(state), S_IDLE);
        press(c_sec, 38, D + 4);
        lit("hold_sec_cook", int'(cookTime), 30);
        lit("hold_sec_model", m_total, 30);
        press(c_min, 3, D + 4);
        lit("glitch_cook", int'(cookTime), 30);

        tap(c_clear);
        repeat (59) tap(c_min);
        repeat (5) tap(c_sec);
        lit("sat_5950_cook", int'(cookTime), 3590);
        lit("sat_5950_model", m_total, 3590);
        lit("sat_5950_sec_t", int'(sec_t), 5);
        tap(c_sec);
        lit("sat_5959_cook", int'(cookTime), 3599);
        tap(c_min);
        lit("sat_min_cook", int'(cookTime), 3599);
        lit("sat_min_model", m_total, 3599);

        tap(c_clear);
        tap(c_start);
        lit("start_zero_state", int'(state), S_IDLE);
        repeat (2) tap(c_min);
        repeat (3) tap(c_sec);
        tap(c_start);
        lit("armed_state", int'(state), S_ARMED);
        lit("armed_tid", int'(timeinputdone), 1);
        tap(c_min);
        lit("armed_min_ignored", int'(cookTime), 150);
        timer_done = 1'b1;
        tick(2);
        timer_done = 1'b0;
        tick(3);
        lit("done_state", int'(state), S_DONE);
        lit("done_alarm", int'(alarm), 1);
        lit("done_tid", int'(timeinputdone), 0);
        tap(c_start);
        lit("rearm_state", int'(state), S_ARMED);
        lit("rearm_cook", int'(cookTime), 150);

        press(c_start | c_clear, D + 2, D + 4);
        lit("start_clear_state", int'(state), S_IDLE);
        lit("start_clear_cook", int'(cookTime), 0);
        lit("start_clear_tid", int'(timeinputdone), 0);

        tap(c_min);
        tap(c_start);
        lit("pre_reset_state", int'(state), S_ARMED);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        lit("midarm_reset_cook", int'(cookTime), 0);
        lit("midarm_reset_state", int'(state), S_IDLE);
        lit("midarm_reset_tid", int'(timeinputdone), 0);
        tick(1);
        rst_n = 1'b1;
        tick(D + 4);

        old_dig = {min_t, min_o, sec_t, sec_o};
        old_ck  = cookTime;
        dig_lat = 0;
        ck_lat  = 0;
        btn_sec = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (dig_lat == 0 && {min_t, min_o, sec_t, sec_o} != old_dig) dig_lat = n;
            if (ck_lat == 0 && cookTime != old_ck) ck_lat = n;
        end
        btn_sec = 1'b0;
        lit("digit_latency", dig_lat, D + 3);
        lit("cook_latency", ck_lat, D + 4);
        tick(D + 6);

        for (int c = 0; c < 4000; c++) begin
            rate = ((c / 500) % 2 == 1) ? 60 : 8;
            if ($urandom_range(0, rate - 1) == 0) btn_min = ~btn_min;
            if ($urandom_range(0, rate - 1) == 0) btn_sec = ~btn_sec;
            if ($urandom_range(0, 24) == 0) btn_start = ~btn_start;
            if ($urandom_range(0, 59) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 14) == 0) timer_done = ~timer_done;
            tick(1);
        end
        drive(4'b1111, 1'b0);
        timer_done = 1'b0;
        tick(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
